// File: rtl/conv_window_feeder_pkg.sv
// Shared types and defaults for the convolution window feeder.
// Imported by the feeder top and its line buffer.
package conv_window_feeder_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int KERNEL_SIZE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_KERNEL,
    STREAM,
    DONE
  } state_e;

  typedef logic [DATA_WIDTH_DEF*KERNEL_SIZE_DEF-1:0] kernel_row_t;

endpackage

// File: rtl/line_buffer.sv
// Column-addressed line buffer holding the previous KERNEL_SIZE-1 rows.
// A write at x shifts that column up one row and inserts the new pixel.
module line_buffer
  import conv_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = 28,
  parameter int XW          = $clog2(IMG_WIDTH)
) (
  input  logic                                    clk,
  input  logic                                    wr_en_i,
  input  logic [XW-1:0]                           x_i,
  input  logic [DATA_WIDTH-1:0]                   pix_i,
  output logic [KERNEL_SIZE-2:0][DATA_WIDTH-1:0]  col_o
);

  logic [DATA_WIDTH-1:0] mem_q [KERNEL_SIZE-1][IMG_WIDTH];

  always_comb begin
    col_o = '0;
    for (int r = 0; r < KERNEL_SIZE-1; r++) begin
      col_o[r] = mem_q[r][x_i];
    end
  end

  // Row 0 is the oldest line; reads see the pre-write contents.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int r = 0; r < KERNEL_SIZE-2; r++) begin
        mem_q[r][x_i] <= mem_q[r+1][x_i];
      end
      mem_q[KERNEL_SIZE-2][x_i] <= pix_i;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Loads a kernel, then streams raster pixels as column slices
// into a convolution stage with window-complete strobes.
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF,
  parameter int IMG_WIDTH   = 28,
  parameter int IMG_HEIGHT  = 28
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [DATA_WIDTH*KERNEL_SIZE-1:0] kernel_row_in,
  input  logic                              kernel_row_valid,
  input  logic [DATA_WIDTH-1:0]             pixel_in,
  input  logic                              pixel_valid,
  output logic                              pixel_ready,
  output logic [DATA_WIDTH-1:0]             data_out0,
  output logic [DATA_WIDTH-1:0]             data_out1,
  output logic [DATA_WIDTH-1:0]             data_out2,
  output logic [DATA_WIDTH-1:0]             data_out3,
  output logic                              conv_valid_in,
  output logic                              conv_kernel_load,
  output logic                              conv_valid_out,
  output logic                              frame_done,
  output logic                              busy
);

  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);
  localparam int KW = $clog2(KERNEL_SIZE);

  state_e state_q, state_d;

  logic [KW-1:0] kcnt_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [KERNEL_SIZE-1:0][DATA_WIDTH-1:0] dout_q;
  logic [KERNEL_SIZE-2:0][DATA_WIDTH-1:0] col;
  logic vin_q, kl_q, win_q, vout_q;
  logic krow, xfer, xwrap, last_px;

  assign krow    = kernel_row_valid && (state_q == LOAD_KERNEL);
  assign xfer    = pixel_valid && (state_q == STREAM);
  assign xwrap   = (x_q == XW'(IMG_WIDTH-1));
  assign last_px = xfer && xwrap && (y_q == YW'(IMG_HEIGHT-1));

  line_buffer #(
    .DATA_WIDTH  (DATA_WIDTH),
    .KERNEL_SIZE (KERNEL_SIZE),
    .IMG_WIDTH   (IMG_WIDTH),
    .XW          (XW)
  ) u_lb (
    .clk     (clk),
    .wr_en_i (xfer),
    .x_i     (x_q),
    .pix_i   (pixel_in),
    .col_o   (col)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:        if (start) state_d = LOAD_KERNEL;
      LOAD_KERNEL: if (krow && kcnt_q == KW'(KERNEL_SIZE-1))
                     state_d = STREAM;
      STREAM:      if (last_px) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kcnt_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      dout_q <= '0;
      vin_q  <= 1'b0;
      kl_q   <= 1'b0;
      win_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      vin_q  <= 1'b0;
      kl_q   <= 1'b0;
      win_q  <= 1'b0;
      vout_q <= win_q;
      if (state_q == IDLE && start) begin
        kcnt_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
      end
      unique case (1'b1)
        krow: begin
          for (int j = 0; j < KERNEL_SIZE; j++) begin
            dout_q[j] <= kernel_row_in[j*DATA_WIDTH +: DATA_WIDTH];
          end
          vin_q  <= 1'b1;
          kl_q   <= 1'b1;
          kcnt_q <= kcnt_q + KW'(1);
        end
        xfer: begin
          x_q <= xwrap ? '0 : x_q + XW'(1);
          if (xwrap) begin
            y_q <= (y_q == YW'(IMG_HEIGHT-1)) ? '0 : y_q + YW'(1);
          end
          // Column push once enough rows are buffered above this one.
          if (y_q >= YW'(KERNEL_SIZE-1)) begin
            for (int j = 0; j < KERNEL_SIZE-1; j++) begin
              dout_q[j] <= col[j];
            end
            dout_q[KERNEL_SIZE-1] <= pixel_in;
            vin_q <= 1'b1;
            win_q <= (x_q >= XW'(KERNEL_SIZE-1));
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out0        = dout_q[0];
  assign data_out1        = dout_q[1];
  assign data_out2        = dout_q[2];
  assign data_out3        = dout_q[3];
  assign conv_valid_in    = vin_q;
  assign conv_kernel_load = kl_q;
  assign conv_valid_out   = vout_q;
  assign pixel_ready      = (state_q == STREAM);
  assign frame_done       = (state_q == DONE);
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_conv_window_feeder.sv
// Scoreboard bench for conv_window_feeder: kernel load, column
// pushes, window strobes, frame completion, abort and busy start.
module tb_conv_window_feeder;

  localparam int DW = 16;
  localparam int K  = 4;
  localparam int W  = 28;
  localparam int H  = 28;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic kernel_row_valid = 1'b0;
  logic pixel_valid = 1'b0;
  logic [DW*K-1:0] kernel_row_in = '0;
  logic [DW-1:0] pixel_in = '0;

  logic pixel_ready, conv_valid_in, conv_kernel_load;
  logic conv_valid_out, frame_done, busy;
  logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;

  conv_window_feeder #(
    .DATA_WIDTH  (DW),
    .KERNEL_SIZE (K),
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .kernel_row_in    (kernel_row_in),
    .kernel_row_valid (kernel_row_valid),
    .pixel_in         (pixel_in),
    .pixel_valid      (pixel_valid),
    .pixel_ready      (pixel_ready),
    .data_out0        (data_out0),
    .data_out1        (data_out1),
    .data_out2        (data_out2),
    .data_out3        (data_out3),
    .conv_valid_in    (conv_valid_in),
    .conv_kernel_load (conv_kernel_load),
    .conv_valid_out   (conv_valid_out),
    .frame_done       (frame_done),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vout_cnt = 0;
  int fd_cnt = 0;
  logic [79:0] sb[$];
  logic prev_vin = 1'b0;
  logic prev_kl = 1'b0;
  logic [DW-1:0] prev_d0 = '0;

  task automatic chk(input string name, input logic [79:0] got,
                     input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every push must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      if (conv_valid_in) begin
        if (sb.size() == 0) begin
          chk("push_unexpected", {conv_kernel_load, data_out3,
              data_out2, data_out1, data_out0}, 80'hx);
        end else begin
          chk("push", {conv_kernel_load, data_out3, data_out2,
              data_out1, data_out0}, sb.pop_front());
        end
      end
      if (conv_valid_out) begin
        vout_cnt++;
        chk("vout_window", {prev_vin, prev_kl,
            (32'(prev_d0) % W) >= 3}, 3'b101);
      end
      if (frame_done) fd_cnt++;
    end
    prev_vin = conv_valid_in;
    prev_kl  = conv_kernel_load;
    prev_d0  = data_out0;
  end

  task automatic load_kernel();
    start = 1'b1;
    tick();
    start = 1'b0;
    kernel_row_in = 64'h0001_0002_0003_0004;
    kernel_row_valid = 1'b1;
    for (int r = 0; r < K; r++) begin
      sb.push_back({1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004});
      tick();
    end
    kernel_row_valid = 1'b0;
    chk("enter_stream", pixel_ready, 1);
  endtask

  task automatic stream(input int abort_y, input bit gaps,
                        input int busy_y);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == abort_y && x == 0) begin
          pixel_valid = 1'b0;
          tick();
          tick();
          chk("abort_busy_before", busy, 1);
          chk("abort_drained", sb.size(), 0);
          rst = 1'b0;
          #1;
          chk("abort_outs", {data_out0, data_out1, data_out2,
              data_out3, conv_valid_in, conv_kernel_load,
              conv_valid_out, frame_done, busy, pixel_ready}, 0);
          tick();
          rst = 1'b1;
          tick();
          chk("abort_idle", {busy, pixel_ready}, 0);
          return;
        end
        if (y == busy_y && x == 0) begin
          pixel_valid = 1'b0;
          start = 1'b1;
          tick();
          start = 1'b0;
          chk("start_busy", {busy, pixel_ready}, 2'b11);
        end
        if (gaps) begin
          for (int g = 0; g < 3 && $urandom_range(0, 3) == 0; g++) begin
            pixel_valid = 1'b0;
            tick();
          end
        end
        pixel_valid = 1'b1;
        pixel_in = DW'(y*W + x);
        if (y >= 3) begin
          sb.push_back({1'b0, 16'(y*W + x), 16'((y-1)*W + x),
                        16'((y-2)*W + x), 16'((y-3)*W + x)});
        end
        chk("ready", pixel_ready, 1);
        tick();
        pixel_valid = 1'b0;
      end
    end
  endtask

  task automatic end_frame();
    repeat (4) tick();
    chk("windows", vout_cnt, (W-3)*(H-3));
    chk("frame_done", fd_cnt, 1);
    chk("sb_empty", sb.size(), 0);
    chk("idle_after", {busy, pixel_ready}, 0);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) tick();
    chk("rst_data", {data_out0, data_out1, data_out2, data_out3}, 0);
    chk("rst_ctrl", {pixel_ready, conv_valid_in, conv_kernel_load,
        conv_valid_out, frame_done, busy}, 0);
    rst = 1'b1;
    tick();

    pixel_valid = 1'b1;
    kernel_row_valid = 1'b1;
    kernel_row_in = 64'h1111_2222_3333_4444;
    repeat (5) begin
      tick();
      chk("idle_ready", {pixel_ready, busy}, 0);
    end
    pixel_valid = 1'b0;
    kernel_row_valid = 1'b0;
    tick();

    vout_cnt = 0;
    fd_cnt = 0;
    load_kernel();
    stream(-1, 1'b1, -1);
    end_frame();

    load_kernel();
    stream(10, 1'b0, -1);
    tick();

    vout_cnt = 0;
    fd_cnt = 0;
    load_kernel();
    stream(-1, 1'b1, 5);
    end_frame();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
